// File: rtl/caled_frame_streamer_pkg.sv
// Shared types for the calibrated-frame streamer: FSM states, beat layout, defaults.
// Latency: n/a (types only).
// Backpressure: n/a.
package caled_frame_streamer_pkg;

  localparam int WORD_W        = 16;
  localparam int N_SAMPLES_DEF = 320;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // One output-FIFO entry: payload word plus packet framing flags.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

endpackage

// File: rtl/st_skid_fifo.sv
// Two-entry beat FIFO feeding the Avalon-ST source.
// Latency: a pushed beat is visible at the head on the next cycle.
// Backpressure: head and valid hold while pop is low; push+pop together keeps occupancy.
module st_skid_fifo
  import caled_frame_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output logic       vld,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  do_push;
  logic  do_pop;

  assign vld     = (count != 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && vld;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/caled_frame_streamer.sv
// Streams a calibrated frame buffer as one Avalon-ST packet: header word (frame_seq) then N_SAMPLES words.
// Latency: read data is pushed the cycle it returns; first beat appears one cycle after the header push.
// Backpressure: reads are throttled so FIFO occupancy plus in-flight reads never exceeds the 2-entry FIFO.
module caled_frame_streamer
  import caled_frame_streamer_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_ready,
  output logic              frame_done,
  output logic [ADDR_W-1:0] data_caled_address,
  output logic              data_caled_rd_enable,
  input  logic [15:0]       data_caled,
  output logic [15:0]       data_out_data,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              data_out_startofpacket,
  output logic              data_out_endofpacket,
  output logic              data_out_empty,
  output logic [15:0]       frame_seq
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N_SAMPLES - 1);

  state_t            state;
  logic              pending;
  logic [15:0]       seq_q;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_dly;
  logic              last_dly;
  logic              rd_go;
  logic              pop;
  logic [2:0]        occ;

  logic              fifo_push;
  beat_t             fifo_in;
  logic              fifo_vld;
  beat_t             fifo_head;
  logic [1:0]        fifo_count;

  assign pop = fifo_vld && data_out_ready;
  // Entries that will be held once this cycle's arriving word and departing beat settle;
  // a new read is safe only if its data will find a free slot next cycle.
  assign occ   = 3'(fifo_count) + 3'(rd_dly) - 3'(pop);
  assign rd_go = (state == STREAM) && (occ < 3'd2);

  assign fifo_push = (state == HEADER) || rd_dly;
  assign fifo_in   = (state == HEADER) ? beat_t'{data: seq_q, sop: 1'b1, eop: 1'b0}
                                       : beat_t'{data: data_caled, sop: 1'b0, eop: last_dly};

  st_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_beat (fifo_in),
    .pop       (pop),
    .vld       (fifo_vld),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign data_out_valid         = fifo_vld;
  assign data_out_data          = fifo_head.data;
  assign data_out_startofpacket = fifo_vld && fifo_head.sop;
  assign data_out_endofpacket   = fifo_vld && fifo_head.eop;
  assign data_out_empty         = 1'b0;
  assign frame_seq              = seq_q;

  assign data_caled_rd_enable = rd_go;
  assign data_caled_address   = rd_go ? rd_idx[ADDR_W-1:0] : addr_q;

  // Track reads in flight so returning words are pushed with the right EOP flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dly   <= 1'b0;
      last_dly <= 1'b0;
      addr_q   <= '0;
    end else begin
      rd_dly   <= rd_go;
      last_dly <= rd_go && (rd_idx == LAST_IDX);
      if (rd_go) begin
        addr_q <= rd_idx[ADDR_W-1:0];
      end
    end
  end

  // Frame sequencing FSM with a single-deep pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      seq_q      <= 16'h0000;
      rd_idx     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (frame_ready || pending) begin
          state   <= HEADER;
          pending <= 1'b0;
        end
      end else if (frame_ready) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: ;
        HEADER: begin
          rd_idx <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          if (rd_go) begin
            rd_idx <= rd_idx + (ADDR_W+1)'(1);
            if (rd_idx == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The EOP beat is the final push, so its departure leaves the FIFO empty.
          if (pop && fifo_head.eop) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          seq_q <= seq_q + 16'h0001;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caled_frame_streamer.sv
// Randomized self-checking bench for caled_frame_streamer against a frame-level reference model.
// Latency: n/a.
// Backpressure: ready is driven always-high, 10/10 toggling or random per scenario.
module tb_caled_frame_streamer;

  localparam int N  = 320;
  localparam int AW = 9;
  localparam int FL = N + 1;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } tb_beat_t;

  logic          clk;
  logic          rst;
  logic          frame_ready;
  logic          frame_done;
  logic [AW-1:0] data_caled_address;
  logic          data_caled_rd_enable;
  logic [15:0]   data_caled;
  logic [15:0]   data_out_data;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_startofpacket;
  logic          data_out_endofpacket;
  logic          data_out_empty;
  logic [15:0]   frame_seq;

  caled_frame_streamer #(.N_SAMPLES(N), .ADDR_W(AW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .frame_ready            (frame_ready),
    .frame_done             (frame_done),
    .data_caled_address     (data_caled_address),
    .data_caled_rd_enable   (data_caled_rd_enable),
    .data_caled             (data_caled),
    .data_out_data          (data_out_data),
    .data_out_valid         (data_out_valid),
    .data_out_ready         (data_out_ready),
    .data_out_startofpacket (data_out_startofpacket),
    .data_out_endofpacket   (data_out_endofpacket),
    .data_out_empty         (data_out_empty),
    .frame_seq              (frame_seq)
  );

  logic [15:0] ram [N];
  tb_beat_t    got[$];
  int          beat_cyc[$];
  int          checks;
  int          errors;
  int          done_cnt;
  int          stall_viol;
  int          ready_mode;
  int          cyc;
  logic        prev_stalled;
  tb_beat_t    prev_beat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: data valid one cycle after the strobe.
  initial begin
    data_caled = 16'h0000;
    forever begin
      @(posedge clk);
      if (data_caled_rd_enable) data_caled <= ram[data_caled_address];
    end
  end

  // Sink ready pattern, changed just after each rising edge.
  initial begin
    data_out_ready = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      case (ready_mode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = ((cyc / 10) % 2) == 0;
        default: data_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Sink monitor: records accepted beats, frame_done pulses and stall stability.
  initial begin
    prev_stalled = 1'b0;
    prev_beat    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stalled = 1'b0;
      end else begin
        if (prev_stalled) begin
          if (!data_out_valid || data_out_data != prev_beat.data ||
              data_out_startofpacket != prev_beat.sop || data_out_endofpacket != prev_beat.eop)
            stall_viol = stall_viol + 1;
        end
        prev_beat    = '{data_out_data, data_out_startofpacket, data_out_endofpacket};
        prev_stalled = data_out_valid && !data_out_ready;
        if (data_out_valid && data_out_ready) begin
          got.push_back(prev_beat);
          beat_cyc.push_back(cyc);
        end
        if (frame_done) done_cnt = done_cnt + 1;
      end
    end
  end

  // Reference: number of beats in got[start +: FL] that differ from the expected packet.
  function automatic int frame_errors(input logic [15:0] seq, input int start);
    tb_beat_t exp_b;
    int       bad;
    if (got.size() < start + FL) return FL;
    bad = 0;
    for (int k = 0; k < FL; k++) begin
      if (k == 0) exp_b = '{seq, 1'b1, 1'b0};
      else        exp_b = '{ram[k-1], 1'b0, (k == N)};
      if (got[start+k] !== exp_b) bad = bad + 1;
    end
    return bad;
  endfunction

  task automatic pulse_frame;
    @(posedge clk); #1 frame_ready = 1'b1;
    @(posedge clk); #1 frame_ready = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_beats(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    beat_cyc.delete();
    done_cnt   = 0;
    stall_viol = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    frame_ready = 1'b0;
    #1;
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    checks++; if ({data_out_startofpacket, data_out_endofpacket} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop: got %b want 00", {data_out_startofpacket, data_out_endofpacket}); end
    checks++; if (data_caled_rd_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_enable: got %b want 0", data_caled_rd_enable); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (frame_seq !== 16'h0000) begin errors++; $display("FAIL reset_frame_seq: got %h want 0000", frame_seq); end
    checks++; if (data_caled_address !== '0) begin errors++; $display("FAIL reset_address: got %h want 0", data_caled_address); end
    checks++; if (data_out_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b want 0", data_out_empty); end
    do_reset();
  endtask

  task automatic test_basic;
    bit ok;
    for (int i = 0; i < N; i++) ram[i] = 16'(i * i);
    ready_mode = 0;
    pulse_frame();
    wait_done(1, 3000, ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: done_cnt %0d want 1", done_cnt); end
    checks++; if (got.size() !== FL) begin errors++; $display("FAIL basic_len: got %0d want %0d", got.size(), FL); end
    checks++; if (got[0] !== tb_beat_t'{16'h0000, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_header: got %h want %h", got[0], tb_beat_t'{16'h0000, 1'b1, 1'b0}); end
    checks++; if (got[17].data !== 16'd256) begin errors++; $display("FAIL basic_beat17: got %h want 0100", got[17].data); end
    checks++; if (got[N].eop !== 1'b1 || got[N].data !== 16'(319 * 319)) begin errors++; $display("FAIL basic_eop: got %h want %h with eop", got[N], tb_beat_t'{16'(319 * 319), 1'b0, 1'b1}); end
    checks++; if (frame_errors(16'h0000, 0) !== 0) begin errors++; $display("FAIL basic_frame: %0d bad beats want 0", frame_errors(16'h0000, 0)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (beat_cyc.size() == FL && beat_cyc[N] - beat_cyc[1] !== N - 1) begin errors++; $display("FAIL basic_throughput: got %0d cycles want %0d", beat_cyc[N] - beat_cyc[1], N - 1); end
    checks++; if (frame_seq !== 16'h0001) begin errors++; $display("FAIL basic_seq: got %h want 0001", frame_seq); end
  endtask

  task automatic test_backpressure;
    bit ok;
    ready_mode = 1;
    stall_viol = 0;
    pulse_frame();
    wait_done(2, 4000, ok);
    repeat (5) @(negedge clk);
    ready_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done_cnt %0d want 2", done_cnt); end
    checks++; if (got.size() !== 2 * FL) begin errors++; $display("FAIL bp_len: got %0d want %0d", got.size(), 2 * FL); end
    checks++; if (frame_errors(16'h0001, FL) !== 0) begin errors++; $display("FAIL bp_frame: %0d bad beats want 0", frame_errors(16'h0001, FL)); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      wait_done(f + 1, 4000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: frame %0d done_cnt %0d", f, done_cnt); end
    end
    repeat (5) @(negedge clk);
    ready_mode = 0;
    for (int f = 0; f < 3; f++) begin
      checks++; if (frame_errors(16'(f), f * FL) !== 0) begin errors++; $display("FAIL b2b_frame%0d: %0d bad beats want 0", f, frame_errors(16'(f), f * FL)); end
    end
    checks++; if (frame_seq !== 16'h0003) begin errors++; $display("FAIL b2b_seq: got %h want 0003", frame_seq); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL b2b_stable: got %0d unstable stalls want 0", stall_viol); end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    pulse_frame();
    wait_done(1, 3000, ok);
    pulse_frame();
    wait_done(2, 3000, ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: done_cnt %0d want 2", done_cnt); end
    checks++; if (frame_errors(16'hFFFF, 0) !== 0) begin errors++; $display("FAIL wrap_first: header %h want ffff, %0d bad beats", got[0].data, frame_errors(16'hFFFF, 0)); end
    checks++; if (frame_errors(16'h0000, FL) !== 0) begin errors++; $display("FAIL wrap_second: header %h want 0000, %0d bad beats", got[FL].data, frame_errors(16'h0000, FL)); end
    checks++; if (frame_seq !== 16'h0001) begin errors++; $display("FAIL wrap_seq: got %h want 0001", frame_seq); end
  endtask

  task automatic test_pending;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
    pulse_frame();
    wait_beats(50, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_start: got %0d beats want 50", got.size()); end
    pulse_frame();
    repeat (5) @(posedge clk);
    pulse_frame();
    wait_done(2, 4000, ok);
    repeat (1500) @(negedge clk);
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL pend_frames: got %0d frame_done want 2", done_cnt); end
    checks++; if (got.size() !== 2 * FL) begin errors++; $display("FAIL pend_len: got %0d want %0d", got.size(), 2 * FL); end
    checks++; if (frame_errors(16'h0000, 0) + frame_errors(16'h0001, FL) !== 0) begin errors++; $display("FAIL pend_data: got %0d bad beats want 0", frame_errors(16'h0000, 0) + frame_errors(16'h0001, FL)); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int eops;
    do_reset();
    for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
    pulse_frame();
    wait_done(1, 3000, ok);
    got.delete();
    pulse_frame();
    wait_beats(100, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_start: got %0d beats want 100", got.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({data_out_valid, data_out_startofpacket, data_out_endofpacket, data_caled_rd_enable, frame_done} !== 5'b0) begin errors++; $display("FAIL rmid_ctrl: got %b want 00000", {data_out_valid, data_out_startofpacket, data_out_endofpacket, data_caled_rd_enable, frame_done}); end
    checks++; if (data_out_data !== 16'h0000 || frame_seq !== 16'h0000 || data_caled_address !== '0) begin errors++; $display("FAIL rmid_data: data %h seq %h addr %h want 0", data_out_data, frame_seq, data_caled_address); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    eops = 0;
    foreach (got[i]) if (got[i].eop) eops++;
    checks++; if (eops !== 0) begin errors++; $display("FAIL rmid_no_eop: got %0d eop beats want 0", eops); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rmid_no_done: got %0d frame_done want 1", done_cnt); end
    got.delete();
    pulse_frame();
    wait_done(2, 3000, ok);
    repeat (5) @(negedge clk);
    checks++; if (frame_errors(16'h0000, 0) !== 0) begin errors++; $display("FAIL rmid_restart: header %h want 0000, %0d bad beats", got[0].data, frame_errors(16'h0000, 0)); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    stall_viol  = 0;
    ready_mode  = 0;
    rst         = 1'b1;
    frame_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_pending();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/caled_frame_streamer.md
CALED_FRAME_STREAMER -- requirements
Module: caled_frame_streamer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 320, meaning the number of calibrated words per frame.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the buffer address width; ceil(log2(N_SAMPLES)) SHALL be <= ADDR_W.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port frame_ready, input, 1 bit: 1-cycle pulse meaning the calibrated buffer holds a complete frame.
REQ-006 SHALL have port frame_done, output, 1 bit: 1-cycle pulse meaning the buffer is released to the writer.
REQ-007 SHALL have port data_caled_address, output, ADDR_W bits: buffer read address.
REQ-008 SHALL have port data_caled_rd_enable, output, 1 bit: buffer read strobe.
REQ-009 SHALL have port data_caled, input, 16 bits: buffer read data, valid exactly 1 cycle after the strobe.
REQ-010 SHALL have Avalon-ST source port data_out_data, output, 16 bits.
REQ-011 SHALL have Avalon-ST source port data_out_valid, output, 1 bit.
REQ-012 SHALL have Avalon-ST source port data_out_ready, input, 1 bit: readyLatency 0.
REQ-013 SHALL have Avalon-ST source ports data_out_startofpacket and data_out_endofpacket, outputs, 1 bit each.
REQ-014 SHALL have Avalon-ST source port data_out_empty, output, 1 bit: constant 0.
REQ-015 SHALL have port frame_seq, output, 16 bits: sequence number of the next frame.

Function
REQ-016 SHALL implement states IDLE, HEADER, STREAM, DRAIN, DONE.
REQ-017 IDLE -> HEADER on frame_ready; frame_ready pulses outside IDLE SHALL be counted in a 1-bit pending flag and served on return to IDLE (no loss of one, no queueing of more).
REQ-018 HEADER SHALL push word frame_seq into the output FIFO as SOP, then go to STREAM.
REQ-019 STREAM SHALL issue reads at addresses 0..N_SAMPLES-1 in order, one per cycle at most, only when FIFO occupancy + reads in flight < 2.
REQ-020 Each returned data_caled word SHALL be pushed into the FIFO the cycle it arrives; the word for address N_SAMPLES-1 SHALL carry EOP.
REQ-021 After the last read is issued -> DRAIN; DRAIN -> DONE when the FIFO is empty and the EOP beat is accepted.
REQ-022 DONE SHALL assert frame_done for exactly 1 cycle, increment frame_seq (mod 2^16 wrap, 0xFFFF -> 0x0000), then go to IDLE.
REQ-023 The output FIFO SHALL have 2 entries of {data, sop, eop}; data_out_valid = FIFO not empty; a beat transfers when valid && ready.
REQ-024 With data_out_ready held high, throughput SHALL be 1 word per cycle; the packet length SHALL be N_SAMPLES+1 words.
REQ-025 Backpressure of any length SHALL lose no word and duplicate no word; valid and data SHALL hold stable while ready is low.
REQ-026 data_caled_rd_enable SHALL be low outside STREAM; data_caled_address SHALL hold its last value when not reading.
REQ-027 Simultaneous FIFO push and pop SHALL keep the occupancy unchanged.

Reset
REQ-028 On rst all state SHALL clear asynchronously: state IDLE, FIFO empty, pending flag 0, frame_seq 0, address 0, rd_enable/valid/sop/eop/frame_done 0.
REQ-029 rst mid-frame SHALL abort the packet without emitting EOP; frame_done SHALL NOT pulse for the aborted frame.

Structure
REQ-030 A shared package SHALL hold the state enumeration, N_SAMPLES default, and the header/sample word width of 16.
REQ-031 The 2-entry output FIFO SHALL be a sub-module named st_skid_fifo.

Verification
REQ-032 The bench SHALL check: RAM[i]=i*i[15:0] with ready high -> 321 beats; beat0 = 0x0000 with SOP; beat k = (k-1)^2; EOP on beat 320; one frame_done.
REQ-033 The bench SHALL check: ready toggling 10 cycles high / 10 low -> an identical beat sequence, no duplicates, data stable while stalled.
REQ-034 The bench SHALL check: 3 frames back-to-back -> header words 0,1,2 and frame_seq = 3 at the end.
REQ-035 The bench SHALL check: frame_seq forced to 0xFFFF -> header 0xFFFF, then 0x0000 on the next frame.
REQ-036 The bench SHALL check: two extra frame_ready pulses during STREAM -> exactly one further frame follows.
REQ-037 The bench SHALL check: rst asserted at beat 100 -> all outputs 0 immediately, no EOP, no frame_done; the next frame restarts with header 0x0000.
